// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N-input registered selector with valid/ready and a 2-entry skid buffer.
// Optional even-parity output port out_par is enabled by defining MUX_NX1_PIPE_PARITY_EN.
module mux_nx1_pipe #(
  parameter int                WIDTH       = 32,
  parameter int                N_IN        = 4,
  parameter int                SEL_W       = 2,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_err,
`ifdef MUX_NX1_PIPE_PARITY_EN
  output logic                  out_par,
`endif
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main_data, r_skid_data;
  logic [SEL_W-1:0] r_main_sel, r_skid_sel;
  logic             r_main_err, r_skid_err;
  logic             r_main_par, r_skid_par;

  logic [WIDTH-1:0] w_word;
  logic             w_hit;
  logic             w_par;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  // Equality against every legal index compares all sel bits, so any sel >= N_IN misses.
  always_comb begin
    w_word = DEFAULT_VAL;
    w_hit  = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_word = in_bus[k*WIDTH +: WIDTH];
        w_hit  = 1'b1;
      end
    end
    w_par = ^w_word;
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = (r_state != ST_EMPTY) && out_ready;

  always_comb begin
    w_state_next   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next = ST_ONE;
          w_load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_TWO;
          w_load_skid  = 1'b1;
        end else if (w_drain) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_drain) begin
          w_state_next   = ST_ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_main_data <= '0;
      r_main_sel  <= '0;
      r_main_err  <= 1'b0;
      r_main_par  <= 1'b0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_skid_err  <= 1'b0;
      r_skid_par  <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_word;
        r_main_sel  <= sel;
        r_main_err  <= !w_hit;
        r_main_par  <= w_par;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
        r_main_sel  <= r_skid_sel;
        r_main_err  <= r_skid_err;
        r_main_par  <= r_skid_par;
      end
      if (w_load_skid) begin
        r_skid_data <= w_word;
        r_skid_sel  <= sel;
        r_skid_err  <= !w_hit;
        r_skid_par  <= w_par;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main_data;
  assign out_sel   = r_main_sel;
  assign out_err   = r_main_err;
`ifdef MUX_NX1_PIPE_PARITY_EN
  assign out_par   = r_main_par;
`else
  logic w_unused_par;
  assign w_unused_par = r_main_par ^ r_skid_par;
`endif

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output stage and a valid/ready handshake.
- Selection and output are clocked, with a 2-entry skid buffer so upstream logic can run at full throughput while downstream stalls.
- Used in the datapath wherever an operand select must cross a pipeline boundary, e.g. ALU-source or write-back select into the next stage register.

Parameters:
- WIDTH, 32, data width of each input and of the output
- N_IN, 4, number of data inputs (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN
- DEFAULT_VAL, 0, value output when sel >= N_IN

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_bus  in  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  input select, sampled with in_valid
- in_valid  in  1  upstream offers sel/in_bus this cycle
- in_ready  out  1  block can accept this cycle
- out_data  out  WIDTH  selected data
- out_sel  out  SEL_W  select that produced out_data
- out_err  out  1  1 when out_data came from an out-of-range sel
- out_valid  out  1  out_data/out_sel/out_err valid
- out_ready  in  1  downstream accepts this cycle

Behaviour:
- Reset is synchronous and active-low: reset_n sampled low on a clk rising edge clears state.
  - Reset values: out_valid=0, out_data=0, out_sel=0, out_err=0.
  - in_ready=1 from the first cycle after reset.
  - Both skid entries are invalidated.
  - Reset mid-transfer discards all held data, with no output beat.
- Accept: an input beat transfers when in_valid && in_ready at the clock edge.
  - Selected word = in_bus[sel*WIDTH +: WIDTH] if sel < N_IN, else DEFAULT_VAL with err=1.
- Output transfer: occurs when out_valid && out_ready.
- Latency: 1 cycle. A beat accepted at edge t appears on out_* after edge t with out_valid=1, provided the output register is empty or drains at edge t.
- Throughput: 1 beat/cycle when out_ready is held high.
- Storage: output register (main) plus one skid register. States are EMPTY (0 held), ONE (main valid), TWO (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> TWO (new beat into skid); accept with drain -> ONE (new beat into main); drain only -> EMPTY.
  - TWO: drain -> ONE, with skid moving to main on the same edge; no accept possible.
- in_ready is registered and equals (state != TWO). It must not combinationally depend on out_ready.
- Ordering: beats leave strictly in acceptance order; none dropped or duplicated.
- While out_valid=1 and out_ready=0, out_data/out_sel/out_err hold stable.
- in_bus or sel changes while not accepted have no effect.
- Select and data are both captured at the accept edge; later input changes do not alter held beats.
- sel bits beyond the log2(N_IN) range are still compared in full; any value >= N_IN is out of range.

Optional Feature:
- Macro: MUX_NX1_PIPE_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit), the even parity of out_data (XOR of all bits), stored alongside each beat.
  - out_par resets to 0 and is valid under the same rules as out_data.
  - For an out-of-range beat, parity is computed on DEFAULT_VAL.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles while in_valid=1 -> out_valid=0, out_data=0, and in_ready=1 after the first clocked cycle with reset_n=1.
- Streaming: N_IN=4, inputs 0x11,0x22,0x33,0x44, out_ready=1, sel=0,1,2,3 on consecutive cycles -> out_data 0x11,0x22,0x33,0x44 on the next four cycles, one per cycle, out_err=0.
- Backpressure: out_ready=0, offer sel=1 then sel=2 -> both accepted, in_ready drops to 0. Third offer stalls. Raise out_ready -> outputs 0x22 then 0x33 then the third beat, with no loss.
- Out of range: N_IN=3, SEL_W=2, DEFAULT_VAL=0xDEAD, sel=3 -> out_data=0xDEAD, out_err=1, out_sel=3.
- Reset mid-operation: state TWO, assert reset_n=0 for one cycle -> out_valid=0 and both entries lost. Next accepted beat (sel=0, 0x11) appears alone.
- Parity (MUX_NX1_PIPE_PARITY_EN defined): sel picks 0x00000007 -> out_par=1; 0x00000003 -> out_par=0.
